// File: rtl/seg_scan_decoder_if.sv
// Bundle between a multiplexed 7-segment display scanner and the decoder
// that reconstructs the displayed 4-digit hex frame.
interface seg_scan_decoder_if;
  logic [3:0]  anode;          // active-low digit enables, [0] = rightmost
  logic [7:0]  digit_seg;      // active-low segments, [6:0] = a..g, [7] = dp
  logic [15:0] value;          // last complete frame, digit3 in [15:12]
  logic [3:0]  dp;             // decimal points of last frame, 1 = lit
  logic [3:0]  err_mask;       // per-digit invalid-glyph flags of last frame
  logic        frame_valid;    // pulse when value/dp/err_mask update
  logic        anode_err;      // pulse per sampled cycle with >1 anode low
  logic        frame_timeout;  // pulse when a partial frame is dropped

  modport master (
    output anode, digit_seg,
    input  value, dp, err_mask, frame_valid, anode_err, frame_timeout
  );

  modport slave (
    input  anode, digit_seg,
    output value, dp, err_mask, frame_valid, anode_err, frame_timeout
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed 4-digit 7-segment display and recovers the shown hex
// value. Each digit must be stable for SETTLE sampled cycles to be captured;
// a frame is published once all four digits have been captured.
module seg_scan_decoder #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input logic                clk,
  input logic                rst,
  seg_scan_decoder_if.slave  bus
);

  localparam logic [7:0]  SettleVal  = 8'(SETTLE);
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  // Returns {invalid, nibble}; invalid glyphs decode to nibble 0.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'h40: decode_glyph = 5'h00;
      7'h79: decode_glyph = 5'h01;
      7'h24: decode_glyph = 5'h02;
      7'h30: decode_glyph = 5'h03;
      7'h19: decode_glyph = 5'h04;
      7'h12: decode_glyph = 5'h05;
      7'h02: decode_glyph = 5'h06;
      7'h78: decode_glyph = 5'h07;
      7'h00: decode_glyph = 5'h08;
      7'h10: decode_glyph = 5'h09;
      7'h08: decode_glyph = 5'h0A;
      7'h03: decode_glyph = 5'h0B;
      7'h46: decode_glyph = 5'h0C;
      7'h21: decode_glyph = 5'h0D;
      7'h06: decode_glyph = 5'h0E;
      7'h0E: decode_glyph = 5'h0F;
      default: decode_glyph = 5'h10;
    endcase
  endfunction

  logic [3:0]       anode_q;
  logic [7:0]       seg_q;
  logic [11:0]      prev_q;
  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [15:0]      idle_q, idle_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0][3:0]  shadow_val_q, shadow_val_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]       shadow_err_q, shadow_err_d;
  logic [15:0]      value_q;
  logic [3:0]       dp_q;
  logic [3:0]       err_q;
  logic             frame_valid_q;
  logic             anode_err_q;
  logic             frame_timeout_q;

  logic [2:0]       low_cnt;
  logic [1:0]       slot;
  logic             one_low;
  logic             multi_low;
  logic             same;
  logic             capture;
  logic             frame_done;
  logic             timeout_hit;
  logic [4:0]       glyph;

  // Input sampling; previous sample kept for the stability comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_q <= '1;
      seg_q   <= '1;
      prev_q  <= '1;
    end else begin
      anode_q <= bus.anode;
      seg_q   <= bus.digit_seg;
      prev_q  <= {anode_q, seg_q};
    end
  end

  // Count active anodes and locate the active slot.
  always_comb begin
    low_cnt = '0;
    slot    = '0;
    for (int i = 0; i < 4; i++) begin
      low_cnt = low_cnt + {2'b00, ~anode_q[i]};
      if (!anode_q[i]) slot = 2'(i);
    end
    one_low   = (low_cnt == 3'd1);
    multi_low = (low_cnt > 3'd1);
    same      = ({anode_q, seg_q} == prev_q);
    glyph     = decode_glyph(seg_q[6:0]);
  end

  // Settle FSM next-state: capture fires on the cycle the count hits SETTLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!one_low) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StSettle: cnt_d = same ? cnt_q + 8'd1 : 8'd1;
        StHold:   cnt_d = same ? cnt_q : 8'd1;
        default:  cnt_d = 8'd1;
      endcase
      if (state_q == StHold && same) begin
        state_d = StHold;
      end else if (cnt_d == SettleVal) begin
        capture = 1'b1;
        state_d = StHold;
      end else begin
        state_d = StSettle;
      end
    end
  end

  // Shadow frame, capture mask and idle/timeout bookkeeping.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_err_d = shadow_err_q;
    idle_d       = idle_q;
    frame_done   = (mask_q == 4'hF);
    mask_d       = frame_done ? 4'h0 : mask_q;
    timeout_hit  = !capture && !frame_done && (mask_q != 4'h0) && (idle_q == TimeoutVal);
    if (timeout_hit) mask_d = 4'h0;
    if (capture) begin
      shadow_val_d[slot] = glyph[3:0];
      shadow_err_d[slot] = glyph[4];
      shadow_dp_d[slot]  = ~seg_q[7];
      mask_d[slot]       = 1'b1;
      idle_d             = '0;
    end else if (idle_q < TimeoutVal) begin
      idle_d = idle_q + 16'd1;
    end
  end

  // State registers and published outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      idle_q          <= '0;
      mask_q          <= '0;
      shadow_val_q    <= '0;
      shadow_dp_q     <= '0;
      shadow_err_q    <= '0;
      value_q         <= '0;
      dp_q            <= '0;
      err_q           <= '0;
      frame_valid_q   <= 1'b0;
      anode_err_q     <= 1'b0;
      frame_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idle_q          <= idle_d;
      mask_q          <= mask_d;
      shadow_val_q    <= shadow_val_d;
      shadow_dp_q     <= shadow_dp_d;
      shadow_err_q    <= shadow_err_d;
      frame_valid_q   <= frame_done;
      anode_err_q     <= multi_low;
      frame_timeout_q <= timeout_hit;
      if (frame_done) begin
        value_q <= shadow_val_q;
        dp_q    <= shadow_dp_q;
        err_q   <= shadow_err_q;
      end
    end
  end

  assign bus.value         = value_q;
  assign bus.dp            = dp_q;
  assign bus.err_mask      = err_q;
  assign bus.frame_valid   = frame_valid_q;
  assign bus.anode_err     = anode_err_q;
  assign bus.frame_timeout = frame_timeout_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: expected frames are queued as each
// scan is driven and compared when frame_valid pulses.
module tb_seg_scan_decoder;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  logic clk;
  logic rst;
  seg_scan_decoder_if bus ();

  seg_scan_decoder #(
    .SETTLE  (4),
    .TIMEOUT (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     total = 0;
  int     bad   = 0;
  int     frames = 0;
  int     aerrs  = 0;
  int     touts  = 0;
  logic   fv_prev = 1'b0;
  frame_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and pulse counters, sampled away from the rising edge.
  always @(negedge clk) begin
    frame_t e;
    if (!rst) begin
      if (bus.frame_valid) begin
        check("fv_width", fv_prev, 0);
        check("sb_depth", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("frame", {bus.value, bus.dp, bus.err_mask}, e);
        end
        frames++;
      end
      if (bus.anode_err) aerrs++;
      if (bus.frame_timeout) touts++;
      fv_prev = bus.frame_valid;
    end
  end

  task automatic scan(input logic [1:0] idx, input logic [7:0] seg, input int n);
    bus.anode     = ~(4'b0001 << idx);
    bus.digit_seg = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.anode     = 4'hF;
    bus.digit_seg = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_value"}, bus.value, 0);
    check({tag, "_dp"}, bus.dp, 0);
    check({tag, "_err"}, bus.err_mask, 0);
    check({tag, "_fv"}, bus.frame_valid, 0);
    check({tag, "_aerr"}, bus.anode_err, 0);
    check({tag, "_tout"}, bus.frame_timeout, 0);
  endtask

  initial begin
    int f0, a0, t0;
    rst           = 1'b1;
    bus.anode     = 4'hF;
    bus.digit_seg = 8'hFF;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    idle(4);

    // Basic frame "0012".
    f0 = frames;
    exp_q.push_back('{value: 16'h0012, dp: 4'h0, err: 4'h0});
    scan(3, 8'hC0, 8); scan(2, 8'hC0, 8); scan(1, 8'hF9, 8); scan(0, 8'hA4, 8);
    idle(6);
    check("basic_count", frames - f0, 1);
    check("basic_value", bus.value, 16'h0012);

    // Digit2 too short: no frame; partial frame then ages out.
    f0 = frames; t0 = touts;
    scan(3, 8'hC0, 8); scan(2, 8'hC0, 3); scan(1, 8'hF9, 8); scan(0, 8'hA4, 8);
    idle(110);
    check("short_count", frames - f0, 0);
    check("short_tout", touts - t0, 1);
    check("short_value", bus.value, 16'h0012);
    exp_q.push_back('{value: 16'h0033, dp: 4'h0, err: 4'h0});
    scan(3, 8'hC0, 8); scan(2, 8'hC0, 8); scan(1, 8'hB0, 8); scan(0, 8'hB0, 8);
    idle(6);
    check("rescan_count", frames - f0, 1);
    check("rescan_value", bus.value, 16'h0033);

    // Blank glyph with dp lit on digit1.
    f0 = frames;
    exp_q.push_back('{value: 16'h8705, dp: 4'b0010, err: 4'b0010});
    scan(3, 8'h80, 8); scan(2, 8'hF8, 8); scan(1, 8'h7F, 8); scan(0, 8'h92, 8);
    idle(6);
    check("blank_count", frames - f0, 1);
    check("blank_err", bus.err_mask, 4'b0010);
    check("blank_dp", bus.dp, 4'b0010);

    // Two anodes low mid-scan.
    f0 = frames; a0 = aerrs;
    exp_q.push_back('{value: 16'h1234, dp: 4'h0, err: 4'h0});
    scan(3, 8'hF9, 8); scan(2, 8'hA4, 8);
    bus.anode = 4'b1100; bus.digit_seg = 8'hC0;
    repeat (6) @(negedge clk);
    scan(1, 8'hB0, 8); scan(0, 8'h99, 8);
    idle(6);
    check("aerr_count", aerrs - a0, 6);
    check("aerr_frames", frames - f0, 1);
    check("aerr_value", bus.value, 16'h1234);

    // Single digit then silence: exactly one timeout.
    f0 = frames; t0 = touts;
    scan(0, 8'hC0, 8);
    idle(130);
    check("tout_count", touts - t0, 1);
    check("tout_frames", frames - f0, 0);
    check("tout_value", bus.value, 16'h1234);

    // Reset mid-frame discards partial captures.
    f0 = frames;
    scan(0, 8'hC0, 8); scan(1, 8'hF9, 8);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    scan(2, 8'hA4, 8); scan(3, 8'hB0, 8);
    idle(10);
    check("midrst_frames", frames - f0, 0);
    check("midrst_value", bus.value, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 4: number of consecutive identical sampled cycles required before a digit is captured (1..255).
REQ-002 Parameter TIMEOUT, default 65535: number of cycles without a capture before a partial frame is discarded (1..65535).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 anode  input  4  multiplexed digit enables, active-low; anode[0] is the least-significant (rightmost) digit.
REQ-006 digit_seg  input  8  segment lines, active-low; bit0=a … bit6=g, bit7=dp.
REQ-007 value  output  16  last complete decoded frame, digit3 in [15:12] down to digit0 in [3:0].
REQ-008 dp  output  4  decimal-point state per digit of last frame; 1 = lit.
REQ-009 err_mask  output  4  per-digit flag of last frame; 1 = glyph was not a valid hex pattern.
REQ-010 frame_valid  output  1  one-cycle pulse when value/dp/err_mask update.
REQ-011 anode_err  output  1  one-cycle pulse on the sampled cycle where more than one anode is low.
REQ-012 frame_timeout  output  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-013 anode and digit_seg are registered once; all decisions use the registered copies (1-cycle input latency).
REQ-014 Glyph table (digit_seg[6:0], hex): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E; any other pattern is invalid.
REQ-015 FSM states: IDLE, SETTLE, HOLD.
REQ-016 IDLE: entered when zero or more than one sampled anode is low; stability counter cleared; no capture.
REQ-017 IDLE -> SETTLE when exactly one anode is low; counter loads 1.
REQ-018 SETTLE: counter increments while sampled {anode,digit_seg} equals the previous sample; any change restarts SETTLE with counter = 1 (or goes to IDLE per REQ-016).
REQ-019 When the counter reaches SETTLE, on that same cycle the digit is captured into a shadow slot selected by the active anode, and the FSM goes to HOLD.
REQ-020 Capture: shadow nibble = decoded glyph, or 0 if invalid; shadow err bit = invalid; shadow dp bit = ~digit_seg[7]; capture-mask bit set.
REQ-021 HOLD: no further capture until sampled {anode,digit_seg} changes; change -> SETTLE or IDLE per REQ-016/017.
REQ-022 Recapturing a digit already in the mask overwrites its shadow slot; mask bit stays set.
REQ-023 The cycle after the capture that makes the mask 4'hF: value, dp, err_mask load from shadow, frame_valid pulses, mask clears to 0.
REQ-024 anode_err pulses on every sampled cycle with two or more anodes low; FSM goes to IDLE; shadow and mask untouched.
REQ-025 A 16-bit idle counter clears on every capture and increments otherwise, saturating; when it reaches TIMEOUT with mask nonzero, mask clears and frame_timeout pulses once; counter then holds until next capture.
REQ-026 Capture and timeout on the same cycle: capture wins, no timeout pulse.
REQ-027 Outputs value, dp, err_mask hold their last values between frames; pulses never last more than one cycle.

Reset
REQ-028 rst asserted: FSM = IDLE, counters = 0, mask = 0, shadow = 0, input registers = all-ones (inactive), value = 16'h0000, dp = 4'h0, err_mask = 4'h0, frame_valid = anode_err = frame_timeout = 0.
REQ-029 Reset mid-frame discards all partial captures; the first frame after reset requires all four digits.

Verification
REQ-030 SETTLE=4; scan anode 0111,1011,1101,1110 with glyphs 40,40,79,24 (dp off), 8 cycles each -> single frame_valid pulse, value=16'h0012, dp=0, err_mask=0.
REQ-031 Same scan with digit2 held only 3 cycles -> no frame_valid; next full scan of 0,0,3,3 -> value=16'h0033.
REQ-032 Digit1 shows 7F (blank) with dp lit, others valid "8","7","-","5" -> value=16'h8705, err_mask=4'b0010, dp=4'b0000 except dp[1] per digit_seg[7]=0 → dp=4'b0010.
REQ-033 anode=4'b1100 for 6 cycles mid-scan -> anode_err pulses each of those sampled cycles, no capture, frame completes normally afterward.
REQ-034 Capture digits 0 and 1, then assert rst for 2 cycles -> all outputs zero; subsequent digits 2,3 alone produce no frame_valid.
REQ-035 TIMEOUT=100; capture one digit, then all anodes high 120 cycles -> frame_timeout pulses exactly once at 100 idle cycles, value unchanged.
